// File: rtl/quadrature_decoder.sv
// quadrature_decoder
// Turns the raw A/B channels of a quadrature encoder into a one-cycle step
// pulse and a direction level for the downstream up/down counter. Each
// channel is synchronised and then glitch-filtered. Any transition in which
// both channels change together is illegal and latches a sticky error flag.
module quadrature_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic enc_a_in,
    input  logic enc_b_in,
    input  logic enable_in,
    input  logic clear_error_in,
    output logic step_out,
    output logic direction_out,
    output logic error_out
);

    localparam int CNT_W  = $clog2(FILTER_LEN + 1);
    localparam int WAIT_W = $clog2(SYNC_STAGES + FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SYNC_STAGES + FILTER_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Up order is 00->01->11->10->00. For a single-bit change, the move is
    // "up" exactly when the old A bit differs from the new B bit.
    function automatic logic f_is_up(input logic [1:0] prev, input logic [1:0] cur);
        return prev[1] ^ cur[0];
    endfunction

    // Both channels changing in the same cycle cannot come from a real encoder.
    function automatic logic f_is_illegal(input logic [1:0] prev, input logic [1:0] cur);
        return &(prev ^ cur);
    endfunction

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [CNT_W-1:0]       r_cnt_a;
    logic [CNT_W-1:0]       r_cnt_b;
    logic                   r_filt_a;
    logic                   r_filt_b;
    logic [WAIT_W-1:0]      r_wait_cnt;
    state_t                 r_state;
    logic [1:0]             r_prev;
    logic                   r_step;
    logic                   r_dir;
    logic                   r_err;

    logic                   w_sync_a;
    logic                   w_sync_b;
    logic [1:0]             w_cur;
    state_t                 w_state_nxt;
    logic [WAIT_W-1:0]      w_wait_nxt;
    logic [1:0]             w_prev_nxt;
    logic                   w_step_nxt;
    logic                   w_dir_nxt;
    logic                   w_err_nxt;

    assign w_sync_a = r_sync_a[SYNC_STAGES-1];
    assign w_sync_b = r_sync_b[SYNC_STAGES-1];
    assign w_cur    = {r_filt_a, r_filt_b};

    // Multi-flop synchronisers bring the asynchronous pins into the clock domain.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], enc_a_in};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], enc_b_in};
        end
    end

    // Glitch filters: a new level must persist FILTER_LEN cycles; while
    // waiting after reset the filtered level simply follows the synchroniser.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_filt_a <= 1'b0;
            r_filt_b <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_filt_a <= w_sync_a;
            r_filt_b <= w_sync_b;
        end else begin
            if (w_sync_a != r_filt_a) begin
                if (r_cnt_a == CNT_LAST) begin
                    r_filt_a <= w_sync_a;
                    r_cnt_a  <= '0;
                end else begin
                    r_cnt_a  <= r_cnt_a + CNT_ONE;
                end
            end else begin
                r_cnt_a <= '0;
            end
            if (w_sync_b != r_filt_b) begin
                if (r_cnt_b == CNT_LAST) begin
                    r_filt_b <= w_sync_b;
                    r_cnt_b  <= '0;
                end else begin
                    r_cnt_b  <= r_cnt_b + CNT_ONE;
                end
            end else begin
                r_cnt_b <= '0;
            end
        end
    end

    // Next-state and next-output decode: settle after reset, then classify
    // each filtered transition as step, illegal or no change.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_prev_nxt  = r_prev;
        w_step_nxt  = 1'b0;
        w_dir_nxt   = r_dir;
        w_err_nxt   = clear_error_in ? 1'b0 : r_err;
        case (r_state)
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_prev_nxt  = w_cur;
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_TRACK;
                end else begin
                    w_wait_nxt  = r_wait_cnt + WAIT_ONE;
                end
            end
            ST_TRACK: begin
                // Position is tracked even while disabled, so re-enabling
                // never sees a stale prev and never emits a catch-up step.
                w_prev_nxt = w_cur;
                if (!enable_in) begin
                    w_step_nxt = 1'b0;
                end else if (f_is_illegal(r_prev, w_cur)) begin
                    w_err_nxt = 1'b1;
                end else if (w_cur != r_prev) begin
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = f_is_up(r_prev, w_cur);
                end else begin
                    w_step_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // State, previous position and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
            r_prev     <= 2'b00;
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_prev     <= w_prev_nxt;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign step_out      = r_step;
    assign direction_out = r_dir;
    assign error_out     = r_err;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder at SYNC_STAGES=2, FILTER_LEN=4.
// Pins are driven 1 ns after a rising edge and outputs sampled at the same
// point, so a pin change is first captured on the next edge and its step
// appears after the 7th edge.
module tb_quadrature_decoder;

    logic clk;
    logic rst_n;
    logic enc_a;
    logic enc_b;
    logic enable;
    logic clr_err;
    logic step;
    logic dir;
    logic err;

    int n_checks = 0;
    int n_pass   = 0;
    int step_cnt = 0;

    quadrature_decoder #(
        .SYNC_STAGES(2),
        .FILTER_LEN (4)
    ) dut (
        .clock_in      (clk),
        .reset_n_in    (rst_n),
        .enc_a_in      (enc_a),
        .enc_b_in      (enc_b),
        .enable_in     (enable),
        .clear_error_in(clr_err),
        .step_out      (step),
        .direction_out (dir),
        .error_out     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every pulse the DUT emits, so stray pulses are visible.
    always @(posedge clk) begin
        if (step === 1'b1) step_cnt <= step_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic a, input logic b);
        rst_n   = 1'b0;
        enc_a   = a;
        enc_b   = b;
        enable  = 1'b1;
        clr_err = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
    endtask

    // One legal pin change, held 10 cycles: pulse exactly after edge 7, one cycle wide.
    task automatic legal_edge(input logic a, input logic b, input logic exp_dir, input string tag);
        int c0;
        c0    = step_cnt;
        enc_a = a;
        enc_b = b;
        repeat (6) tick();
        chk({tag, "_early"}, step, 32'd0);
        chk({tag, "_cnt0"}, step_cnt - c0, 32'd0);
        tick();
        chk({tag, "_step"}, step, 32'd1);
        chk({tag, "_dir"}, dir, {31'd0, exp_dir});
        tick();
        chk({tag, "_width"}, step, 32'd0);
        repeat (2) tick();
        chk({tag, "_one"}, step_cnt - c0, 32'd1);
    endtask

    // Both pins change together: error set on edge 7, no step, direction held.
    task automatic illegal_edge(input logic a, input logic b, input logic with_clear,
                                input logic exp_dir, input string tag);
        int c0;
        c0    = step_cnt;
        enc_a = a;
        enc_b = b;
        repeat (6) tick();
        clr_err = with_clear;
        tick();
        clr_err = 1'b0;
        chk({tag, "_err"}, err, 32'd1);
        chk({tag, "_dir"}, dir, {31'd0, exp_dir});
        repeat (3) tick();
        chk({tag, "_nostep"}, step_cnt - c0, 32'd0);
        chk({tag, "_sticky"}, err, 32'd1);
    endtask

    task automatic clear_error(input string tag);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk(tag, err, 32'd0);
    endtask

    initial begin
        int c0;
        rst_n   = 1'b0;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        enable  = 1'b1;
        clr_err = 1'b0;
        tick();
        chk("rst_step", step, 32'd0);
        chk("rst_dir", dir, 32'd0);
        chk("rst_err", err, 32'd0);

        // 1: come out of reset with both pins high
        c0 = step_cnt;
        do_reset(1'b1, 1'b1);
        chk("t1_nostep", step_cnt - c0, 32'd0);
        chk("t1_err", err, 32'd0);

        // 2: up sequence from 00
        do_reset(1'b0, 1'b0);
        c0 = step_cnt;
        legal_edge(1'b0, 1'b1, 1'b1, "up01");
        legal_edge(1'b1, 1'b1, 1'b1, "up11");
        legal_edge(1'b1, 1'b0, 1'b1, "up10");
        legal_edge(1'b0, 1'b0, 1'b1, "up00");
        chk("t2_total", step_cnt - c0, 32'd4);

        // 3: down sequence, then one up edge
        c0 = step_cnt;
        legal_edge(1'b1, 1'b0, 1'b0, "dn10");
        legal_edge(1'b1, 1'b1, 1'b0, "dn11");
        legal_edge(1'b0, 1'b1, 1'b0, "dn01");
        legal_edge(1'b0, 1'b0, 1'b0, "dn00");
        chk("t3_total", step_cnt - c0, 32'd4);
        legal_edge(1'b0, 1'b1, 1'b1, "up_after_dn");

        // 4: 3-cycle glitch on A is rejected; A held high is accepted (01->11 up)
        c0    = step_cnt;
        enc_a = 1'b1;
        repeat (3) tick();
        enc_a = 1'b0;
        repeat (15) tick();
        chk("glitch3", step_cnt - c0, 32'd0);
        legal_edge(1'b1, 1'b1, 1'b1, "glitch_long");

        // Walk down to 00 so direction is 0 before the illegal edge
        legal_edge(1'b0, 1'b1, 1'b0, "dn_to01");
        legal_edge(1'b0, 1'b0, 1'b0, "dn_to00");

        // 5: illegal edge, clear, then clear coincident with illegal edge
        illegal_edge(1'b1, 1'b1, 1'b0, 1'b0, "ill_00_11");
        clear_error("clr_err");
        illegal_edge(1'b0, 1'b0, 1'b1, 1'b0, "ill_clr_same");
        clear_error("clr_err2");

        // 6: disabled tracking, then re-enable and take one up edge
        c0     = step_cnt;
        enable = 1'b0;
        enc_b  = 1'b1;
        repeat (10) tick();
        enc_a  = 1'b1;
        repeat (10) tick();
        chk("dis_nostep", step_cnt - c0, 32'd0);
        chk("dis_dir", dir, 32'd0);
        chk("dis_err", err, 32'd0);
        enable = 1'b1;
        repeat (5) tick();
        chk("reen_nocatchup", step_cnt - c0, 32'd0);
        legal_edge(1'b1, 1'b0, 1'b1, "reen_up");
        chk("reen_err", err, 32'd0);

        // Reset asserted while a step pulse is high
        enc_a = 1'b0;
        repeat (7) tick();
        chk("pre_rst_step", step, 32'd1);
        chk("pre_rst_dir", dir, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_step", step, 32'd0);
        chk("midrst_dir", dir, 32'd0);
        chk("midrst_err", err, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
